// File: rtl/lvds_pll_seq_pkg.sv
// Shared definitions for the LVDS receive PLL sequencer.
//  - state_t : FSM state encoding (RESET, WAIT_LOCK, STABLE, RUN, FAIL)
//  - *_DEF   : default timing constants
//  - cnt_w() : bits needed to hold a counter that counts up to v
package lvds_pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int RST_CYC_DEF      = 200;
  localparam int LOCK_TIMEOUT_DEF = 4096;
  localparam int STABLE_CYC_DEF   = 64;
  localparam int MAX_RETRY_DEF    = 3;
  localparam int LOSS_FILT_DEF    = 4;

  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/lvds_pll_seq_bit_sync.sv
// Two-flop synchroniser for a single asynchronous level.
//  clk : destination clock
//  rst : synchronous active-high reset (both flops cleared)
//  d   : asynchronous input
//  q   : synchronised output, two clk cycles behind d
module lvds_pll_seq_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lvds_pll_seq.sv
// Power-up / recovery sequencer for the LVDS receive PLL.
// Holds the PLL in reset, waits for a filtered lock, and only then releases
// the downstream receive reset. Restarts on loss of lock, on lock timeout
// (up to MAX_RETRY attempts, then sticky fail) or on I_relock.
//
// Ports:
//  I_clk        in   reference clock
//  I_rst        in   synchronous active-high reset
//  I_pll_lock   in   raw PLL lock (asynchronous)
//  I_relock     in   one-cycle restart request
//  O_pll_rst    out  PLL reset
//  O_rx_rst     out  downstream receive reset (low only in RUN)
//  O_ready      out  high only in RUN
//  O_fail       out  sticky: retries exhausted
//  O_retry_cnt  out  failed attempts in the current sequence
//  O_relock_cnt out  saturating count of lock losses seen in RUN
//
// Build option: define PLL_LOSS_FILTER_EN to require LOSS_FILT consecutive
// low lock cycles in RUN before declaring loss; otherwise the first low
// cycle counts as loss.
module lvds_pll_seq
  import lvds_pll_seq_pkg::*;
#(
  parameter int RST_CYC      = RST_CYC_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int STABLE_CYC   = STABLE_CYC_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF,
  parameter int LOSS_FILT    = LOSS_FILT_DEF
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_pll_lock,
  input  logic       I_relock,
  output logic       O_pll_rst,
  output logic       O_rx_rst,
  output logic       O_ready,
  output logic       O_fail,
  output logic [3:0] O_retry_cnt,
  output logic [7:0] O_relock_cnt
);

`ifdef PLL_LOSS_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  // With the filter off a threshold of one low cycle gives immediate loss,
  // so RUN uses the same counter path either way.
  localparam int LOSS_N = FILT_ON ? LOSS_FILT : 1;

  localparam int RW = cnt_w(RST_CYC);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int SW = cnt_w(STABLE_CYC);
  localparam int FW = cnt_w(LOSS_N);

  state_t        state;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] wait_cnt;
  logic [SW-1:0] stab_cnt;
  logic [FW-1:0] filt_cnt;
  logic          lock_s;
  logic [3:0]    retry_nxt;

  lvds_pll_seq_bit_sync u_lock_sync (
    .clk (I_clk),
    .rst (I_rst),
    .d   (I_pll_lock),
    .q   (lock_s)
  );

  assign retry_nxt = O_retry_cnt + 4'd1;

  // Outputs are registered alongside the state they belong to, so each
  // output changes on the same edge the state changes.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state        <= RESET;
      rst_cnt      <= '0;
      wait_cnt     <= '0;
      stab_cnt     <= '0;
      filt_cnt     <= '0;
      O_pll_rst    <= 1'b1;
      O_rx_rst     <= 1'b1;
      O_ready      <= 1'b0;
      O_fail       <= 1'b0;
      O_retry_cnt  <= '0;
      O_relock_cnt <= '0;
    end else if (I_relock) begin
      // restart from scratch; the loss history is kept
      state       <= RESET;
      rst_cnt     <= '0;
      wait_cnt    <= '0;
      stab_cnt    <= '0;
      filt_cnt    <= '0;
      O_pll_rst   <= 1'b1;
      O_rx_rst    <= 1'b1;
      O_ready     <= 1'b0;
      O_fail      <= 1'b0;
      O_retry_cnt <= '0;
    end else begin
      case (state)
        RESET: begin
          if (rst_cnt == RW'(RST_CYC - 1)) begin
            state     <= WAIT_LOCK;
            rst_cnt   <= '0;
            wait_cnt  <= '0;
            O_pll_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state    <= STABLE;
            wait_cnt <= '0;
            stab_cnt <= '0;
          end else if (wait_cnt == TW'(LOCK_TIMEOUT - 1)) begin
            wait_cnt    <= '0;
            O_retry_cnt <= retry_nxt;
            O_pll_rst   <= 1'b1;
            if (retry_nxt == 4'(MAX_RETRY)) begin
              state  <= FAIL;
              O_fail <= 1'b1;
            end else begin
              state   <= RESET;
              rst_cnt <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            // not a failed attempt: go back and wait with a fresh timer
            state    <= WAIT_LOCK;
            wait_cnt <= '0;
            stab_cnt <= '0;
          end else if (stab_cnt == SW'(STABLE_CYC - 1)) begin
            state       <= RUN;
            stab_cnt    <= '0;
            filt_cnt    <= '0;
            O_rx_rst    <= 1'b0;
            O_ready     <= 1'b1;
            O_retry_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        RUN: begin
          if (lock_s) begin
            filt_cnt <= '0;
          end else if (filt_cnt == FW'(LOSS_N - 1)) begin
            state     <= RESET;
            rst_cnt   <= '0;
            filt_cnt  <= '0;
            O_pll_rst <= 1'b1;
            O_rx_rst  <= 1'b1;
            O_ready   <= 1'b0;
            if (O_relock_cnt != 8'hFF) O_relock_cnt <= O_relock_cnt + 8'd1;
          end else begin
            filt_cnt <= filt_cnt + 1'b1;
          end
        end
        FAIL: begin
          // parked until I_rst or I_relock
        end
        default: begin
          state     <= RESET;
          rst_cnt   <= '0;
          O_pll_rst <= 1'b1;
          O_rx_rst  <= 1'b1;
          O_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
